heap_drain: RTL and testbench

//  Receive side of the heap buffer output stream. Captures each valid 344-bit heap record
//  (record bus + valid strobe, no backpressure upstream) into a small circular record queue.

---
 rtl/heap_pkg.sv | 14 +
 rtl/heap_rec_queue.sv | 52 +++++
 rtl/heap_drain.sv | 129 ++++++++++++
 tb/tb_heap_drain.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
// Shared definitions for the heap buffer output path: record/beat geometry
// and the drain FSM state encoding.
package heap_pkg;

  localparam int unsigned HEAP_REC_W  = 344;
  localparam int unsigned HEAP_BEAT_W = 8;
  localparam int unsigned HEAP_BEATS  = HEAP_REC_W / HEAP_BEAT_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;

endpackage

// File: rtl/heap_rec_queue.sv
// Circular DEPTH x W record queue. Pointers carry an extra wrap bit so that
// full and empty are told apart by the top bit alone. The caller guarantees
// push is never asserted on a full queue unless pop is asserted with it.
module heap_rec_queue
  import heap_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = HEAP_REC_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic [PW:0]  diff;

  assign diff  = wr_ptr - rd_ptr;
  assign level = LW'(diff);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[PW-1:0]];

  // Record storage; when full with a simultaneous pop, the write lands on the
  // slot being read, and the reader takes the old value at this same edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= din;
  end

  // Read and write pointers, wrapping naturally through the extra bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/heap_drain.sv
// Receive side of the heap buffer output stream: queues incoming records and
// serializes them LSB beat first onto a valid/ready byte stream. Upstream has
// no backpressure, so a record arriving at a full queue is dropped and
// flagged in a sticky overflow bit.
module heap_drain
  import heap_pkg::*;
#(
  parameter int unsigned REC_W  = HEAP_REC_W,
  parameter int unsigned BEAT_W = HEAP_BEAT_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [REC_W-1:0]             rec_data,
  input  logic                         rec_valid,
  output logic [BEAT_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  input  logic                         ovf_clr
);

  localparam int unsigned BEATS = REC_W / BEAT_W;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  drain_state_t      state;
  logic [REC_W-1:0]  shreg;
  logic [BW-1:0]     beat;
  logic [REC_W-1:0]  q_head;
  logic              q_full;
  logic              q_empty;
  logic              hs;
  logic              at_last;
  logic              pop;
  logic              push;
  logic              drop;

  heap_rec_queue #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (rec_data),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .level (level)
  );

  // The current beat is always the low slice of the shift register, so
  // out_data is a register output that holds while the sink stalls.
  assign out_data = shreg[BEAT_W-1:0];

  assign hs      = out_valid && out_ready;
  assign at_last = (beat == LAST_BEAT);

  // Queue control: a pop only ever happens as part of a load into the shift
  // register, and a pop frees the slot an incoming record needs when full.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    if (!q_empty && ((state == IDLE) || (hs && at_last))) pop = 1'b1;
    if (rec_valid) begin
      if (!q_full || pop) push = 1'b1;
      else                drop = 1'b1;
    end
  end

  // Drain FSM with registered stream outputs; a last-beat handshake with a
  // non-empty queue reloads directly so records stream without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      beat      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg     <= q_head;
            beat      <= '0;
            out_valid <= 1'b1;
            out_last  <= (LAST_BEAT == '0);
            state     <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            if (at_last) begin
              if (pop) begin
                shreg     <= q_head;
                beat      <= '0;
                out_valid <= 1'b1;
                out_last  <= (LAST_BEAT == '0);
              end else begin
                beat      <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                state     <= IDLE;
              end
            end else begin
              shreg    <= shreg >> BEAT_W;
              beat     <= beat + 1'b1;
              out_last <= ((beat + 1'b1) == LAST_BEAT);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_heap_drain.sv
// Directed bench for heap_drain: reset, single record, backpressure,
// back-to-back records, overflow and full-with-pop coincidence.
module tb_heap_drain;

  localparam int REC_W = 344;
  localparam int BEATS = 43;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [REC_W-1:0] rec_data = '0;
  logic             rec_valid = 1'b0;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_last;
  logic [2:0]       level;
  logic             overflow;
  logic             ovf_clr = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]       got_d[$];
  logic             got_l[$];
  logic [REC_W-1:0] exp_recs[$];

  heap_drain #(
    .REC_W  (344),
    .BEAT_W (8),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rec_data  (rec_data),
    .rec_valid (rec_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .level     (level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [REC_W-1:0] mk(input logic [7:0] seed);
    logic [REC_W-1:0] r;
    r = '0;
    for (int k = 0; k < BEATS; k++) r[k*8 +: 8] = seed + 8'(k + 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture a handshake about to happen, advance one cycle, and confirm a
  // stalled beat held its value.
  task automatic step();
    logic       stall;
    logic [7:0] d;
    logic       l;
    stall = out_valid && !out_ready;
    d = out_data;
    l = out_last;
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
    end
    tick();
    if (stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, d);
      check("hold_last", out_last, l);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rec_valid = 1'b0;
    ovf_clr = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    got_d.delete();
    got_l.delete();
    exp_recs.delete();
  endtask

  task automatic verify(input string tag);
    logic [REC_W-1:0] r;
    int n;
    n = exp_recs.size() * BEATS;
    check({tag, "_count"}, got_d.size(), n);
    for (int i = 0; i < got_d.size() && i < n; i++) begin
      r = exp_recs[i / BEATS];
      check({tag, "_data"}, got_d[i], r[(i % BEATS)*8 +: 8]);
      check({tag, "_last"}, got_l[i], (i % BEATS) == BEATS - 1);
    end
  endtask

  initial begin
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int gaps;
    int vcnt;
    logic [REC_W-1:0] r;

    // Reset values
    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);

    // 1: reset mid-record at beat 20
    out_ready = 1'b1;
    rec_data = mk(8'h00);
    rec_valid = 1'b1;
    tick();
    rec_valid = 1'b0;
    for (int c = 0; c < 100 && got_d.size() < 20; c++) step();
    check("t1_beat20", out_data, 8'h15);
    rst_n = 1'b0;
    #1;
    check("t1_async_valid", out_valid, 0);
    check("t1_async_data", out_data, 0);
    tick();
    check("t1_valid", out_valid, 0);
    check("t1_last", out_last, 0);
    check("t1_data", out_data, 0);
    check("t1_level", level, 0);
    check("t1_ovf", overflow, 0);
    rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 50; c++) begin
      if (out_valid) vcnt++;
      tick();
    end
    check("t1_no_beats", vcnt, 0);
    check("t1_level_after", level, 0);

    // 2: single record, latency and full beat sequence
    do_reset();
    out_ready = 1'b1;
    rec_data = mk(8'h00);
    exp_recs.push_back(mk(8'h00));
    rec_valid = 1'b1;
    tick();
    rec_valid = 1'b0;
    check("t2_lat1_valid", out_valid, 0);
    tick();
    check("t2_lat2_valid", out_valid, 1);
    check("t2_first", out_data, 8'h01);
    for (int k = 0; k < BEATS; k++) begin
      check("t2_contig", out_valid, 1);
      step();
    end
    check("t2_end_valid", out_valid, 0);
    verify("t2");

    // 3: backpressure 1,0,0,1
    do_reset();
    rec_data = mk(8'h55);
    exp_recs.push_back(mk(8'h55));
    rec_valid = 1'b1;
    tick();
    rec_valid = 1'b0;
    for (int c = 0; c < 300 && got_d.size() < BEATS; c++) begin
      out_ready = pat[c % 4];
      step();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) step();
    verify("t3");

    // 4: three records on alternate cycles, back-to-back output
    do_reset();
    out_ready = 1'b1;
    exp_recs.push_back(mk(8'h40));
    exp_recs.push_back(mk(8'h80));
    exp_recs.push_back(mk(8'hC0));
    gaps = 0;
    for (int c = 0; c < 200; c++) begin
      rec_valid = (c == 0) || (c == 2) || (c == 4);
      r = exp_recs[(c / 2) % 3];
      rec_data = r;
      if (got_d.size() > 0 && got_d.size() < 3 * BEATS && !out_valid) gaps++;
      step();
    end
    rec_valid = 1'b0;
    check("t4_gaps", gaps, 0);
    verify("t4");

    // 5: overflow with sink stalled
    do_reset();
    out_ready = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      rec_data = mk(8'(n * 16));
      if (n <= 5) exp_recs.push_back(mk(8'(n * 16)));
      rec_valid = 1'b1;
      tick();
    end
    rec_valid = 1'b0;
    tick();
    check("t5_level", level, 4);
    check("t5_ovf", overflow, 1);
    check("t5_valid", out_valid, 1);
    check("t5_head", out_data, 8'h11);
    rec_data = mk(8'h70);
    rec_valid = 1'b1;
    ovf_clr = 1'b1;
    tick();
    rec_valid = 1'b0;
    ovf_clr = 1'b0;
    check("t5_set_wins", overflow, 1);
    check("t5_level2", level, 4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t5_clr", overflow, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 400 && got_d.size() < 5 * BEATS; c++) step();
    for (int c = 0; c < 3; c++) step();
    verify("t5");
    check("t5_level_end", level, 0);
    check("t5_valid_end", out_valid, 0);

    // 6: full queue, last-beat pop coincides with a new record
    do_reset();
    out_ready = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      rec_data = mk(8'(n * 16));
      exp_recs.push_back(mk(8'(n * 16)));
      rec_valid = 1'b1;
      tick();
    end
    rec_valid = 1'b0;
    tick();
    check("t6_full", level, 4);
    out_ready = 1'b1;
    for (int c = 0; c < 100 && !(out_valid && out_last); c++) step();
    check("t6_at_last", out_last, 1);
    rec_data = mk(8'h99);
    exp_recs.push_back(mk(8'h99));
    rec_valid = 1'b1;
    step();
    rec_valid = 1'b0;
    check("t6_level", level, 4);
    check("t6_ovf", overflow, 0);
    for (int c = 0; c < 600 && got_d.size() < 6 * BEATS; c++) step();
    verify("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
